// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life step engine and its helpers:
// FSM state encoding, B3/S23 rule constants, default grid geometry and a
// neighbour-count helper also used by the display preview.
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BIRTH_N   = 4'd3;
  localparam logic [3:0] SURVIVE_N = 4'd2;

  localparam int DEF_WIDTH  = 1024;
  localparam int DEF_HEIGHT = 768;

  // Counts the live cells of a row-major 3x3 window, excluding the centre (bit 4).
  function automatic logic [3:0] neighbour_count(input logic [8:0] w);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (i != 4) begin
        n = n + {3'b000, w[i]};
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/life_step_engine_if.sv
// Control and RAM bus of the life step engine. The engine uses the slave
// modport; the environment (controller plus both cell RAMs) uses master.
// Optional LIFE_POPCOUNT_EN adds the population result.
interface life_step_engine_if #(
  parameter int ADDR_W = 24
);
  logic              start;
  logic              clear_mode;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] src_addr;
  logic              src_rden;
  logic              src_q;
  logic [ADDR_W-1:0] dst_addr;
  logic              dst_data;
  logic              dst_wren;
  logic [31:0]       gen_count;
`ifdef LIFE_POPCOUNT_EN
  logic [ADDR_W-1:0] population;
`endif

  modport slave (
    input  start, clear_mode, src_q,
    output busy, done, src_addr, src_rden, dst_addr, dst_data, dst_wren, gen_count
`ifdef LIFE_POPCOUNT_EN
    , output population
`endif
  );

  modport master (
    output start, clear_mode, src_q,
    input  busy, done, src_addr, src_rden, dst_addr, dst_data, dst_wren, gen_count
`ifdef LIFE_POPCOUNT_EN
    , input population
`endif
  );
endinterface

// File: rtl/life_rule_cell.sv
// B3/S23 rule for one cell. Window is row-major 3x3, bit 4 is the centre.
// Purely combinational so the display preview can reuse it.
module life_rule_cell
  import life_pkg::*;
(
  input  logic [8:0] win,
  output logic       next
);

  logic [3:0] n_s;

  // Birth on exactly three neighbours, survival of a live centre on two.
  always_comb begin
    n_s = neighbour_count(win);
    if (n_s == BIRTH_N) begin
      next = 1'b1;
    end else if (win[4] && (n_s == SURVIVE_N)) begin
      next = 1'b1;
    end else begin
      next = 1'b0;
    end
  end

endmodule

// File: rtl/life_step_engine.sv
// Computes one Game-of-Life generation by streaming the source cell RAM
// through a 3x3 window fed by two line buffers, writing the next generation
// into a separate destination RAM. The scan covers a virtual (HEIGHT+1) x
// (WIDTH+1) grid so that the trailing row/column flush the window with dead
// cells. Pipeline: read issue -> window shift -> registered write.
// Optional feature macro: LIFE_POPCOUNT_EN (population of the last run).
module life_step_engine
  import life_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = 24
) (
  input  logic               clk_in,
  input  logic               reset,
  life_step_engine_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH);
  localparam logic [RW-1:0] R_LAST = RW'(HEIGHT);

  state_e            state_r, state_s;
  logic              accept_s, busy_s, done_s;
  logic              drain_cnt_r;
  logic              busy_r, done_r;
  logic [31:0]       gen_count_r;
  logic              clear_r;

  // Stage 1: virtual scan position and read request
  logic [RW-1:0]     scan_r_r, nxt_r_s;
  logic [CW-1:0]     scan_c_r, nxt_c_s;
  logic              in_grid_r, wr_pos_r;
  logic              last_pos_s, nxt_in_s, nxt_wr_s;
  logic              src_rden_r;
  logic [ADDR_W-1:0] src_addr_r, rd_next_r;

  // Stage 2: window input
  logic              s2_valid_r, s2_in_r, s2_wr_r;
  logic [CW-1:0]     s2_c_r;
  logic [IW-1:0]     lb_idx_s;
  logic              top_s, mid_s, bot_s, left_edge_s;
  logic [8:0]        win_r, win_nxt_s;
  logic [WIDTH-1:0]  lb0_r, lb1_r;

  // Stage 3: rule evaluation and write
  logic              s3_wr_r;
  logic              next_s;
  logic              dst_wren_r, dst_data_r;
  logic [ADDR_W-1:0] dst_addr_r, wr_next_r;

  life_rule_cell u_rule (
    .win  (win_r),
    .next (next_s)
  );

  // Row-major successor of the current virtual scan position.
  always_comb begin
    if (scan_c_r == C_LAST) begin
      nxt_c_s = CW'(0);
      nxt_r_s = scan_r_r + RW'(1);
    end else begin
      nxt_c_s = scan_c_r + CW'(1);
      nxt_r_s = scan_r_r;
    end
    last_pos_s = (scan_r_r == R_LAST) && (scan_c_r == C_LAST);
    nxt_in_s   = (nxt_r_s < R_LAST) && (nxt_c_s < C_LAST);
    nxt_wr_s   = (nxt_r_s != RW'(0)) && (nxt_c_s != CW'(0));
  end

  // Next-state and registered-output decode for the run controller.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s  = ST_SCAN;
          accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (last_pos_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_DONE);
  end

  // Controller state, drain timer, status outputs and generation counter.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      gen_count_r <= 32'd0;
      clear_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= (state_r == ST_DRAIN) ? ~drain_cnt_r : 1'b0;
      busy_r      <= busy_s;
      done_r      <= done_s;
      gen_count_r <= done_s ? gen_count_r + 32'd1 : gen_count_r;
      clear_r     <= accept_s ? bus.clear_mode : clear_r;
    end
  end

  // Stage 1: step the scan counters and issue source reads for real cells.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      scan_r_r   <= RW'(0);
      scan_c_r   <= CW'(0);
      in_grid_r  <= 1'b0;
      wr_pos_r   <= 1'b0;
      src_rden_r <= 1'b0;
      src_addr_r <= ADDR_W'(0);
      rd_next_r  <= ADDR_W'(0);
    end else if (accept_s) begin
      scan_r_r   <= RW'(0);
      scan_c_r   <= CW'(0);
      in_grid_r  <= 1'b1;
      wr_pos_r   <= 1'b0;
      src_rden_r <= ~bus.clear_mode;
      src_addr_r <= ADDR_W'(0);
      rd_next_r  <= ADDR_W'(1);
    end else if ((state_r == ST_SCAN) && !last_pos_s) begin
      scan_r_r   <= nxt_r_s;
      scan_c_r   <= nxt_c_s;
      in_grid_r  <= nxt_in_s;
      wr_pos_r   <= nxt_wr_s;
      src_rden_r <= nxt_in_s & ~clear_r;
      if (nxt_in_s) begin
        src_addr_r <= rd_next_r;
        rd_next_r  <= rd_next_r + ADDR_W'(1);
      end else begin
        src_addr_r <= src_addr_r;
        rd_next_r  <= rd_next_r;
      end
    end else begin
      src_rden_r <= 1'b0;
    end
  end

  // Stage 2 tags: align position information with the returning read data.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_in_r    <= 1'b0;
      s2_wr_r    <= 1'b0;
      s2_c_r     <= CW'(0);
    end else begin
      s2_valid_r <= (state_r == ST_SCAN);
      s2_in_r    <= in_grid_r & ~clear_r;
      s2_wr_r    <= wr_pos_r;
      s2_c_r     <= scan_c_r;
    end
  end

  // New window column from the line buffers and the (possibly injected) cell.
  always_comb begin
    lb_idx_s    = s2_c_r[IW-1:0];
    left_edge_s = (s2_c_r == CW'(0));
    if (s2_c_r < C_LAST) begin
      top_s = lb1_r[lb_idx_s];
      mid_s = lb0_r[lb_idx_s];
    end else begin
      top_s = 1'b0;
      mid_s = 1'b0;
    end
    bot_s = s2_in_r ? bus.src_q : 1'b0;
    win_nxt_s[0] = left_edge_s ? 1'b0 : win_r[1];
    win_nxt_s[1] = left_edge_s ? 1'b0 : win_r[2];
    win_nxt_s[2] = top_s;
    win_nxt_s[3] = left_edge_s ? 1'b0 : win_r[4];
    win_nxt_s[4] = left_edge_s ? 1'b0 : win_r[5];
    win_nxt_s[5] = mid_s;
    win_nxt_s[6] = left_edge_s ? 1'b0 : win_r[7];
    win_nxt_s[7] = left_edge_s ? 1'b0 : win_r[8];
    win_nxt_s[8] = bot_s;
  end

  // Window shift and line-buffer update; buffers start each run all dead.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      win_r <= 9'd0;
      lb0_r <= {WIDTH{1'b0}};
      lb1_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      win_r <= 9'd0;
      lb0_r <= {WIDTH{1'b0}};
      lb1_r <= {WIDTH{1'b0}};
    end else if (s2_valid_r) begin
      win_r <= win_nxt_s;
      if (s2_c_r < C_LAST) begin
        lb1_r[lb_idx_s] <= mid_s;
        lb0_r[lb_idx_s] <= bot_s;
      end else begin
        lb1_r <= lb1_r;
        lb0_r <= lb0_r;
      end
    end else begin
      win_r <= win_r;
    end
  end

  // Stage 3: write the centre cell's next state once its window is complete.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      s3_wr_r    <= 1'b0;
      dst_wren_r <= 1'b0;
      dst_data_r <= 1'b0;
      dst_addr_r <= ADDR_W'(0);
      wr_next_r  <= ADDR_W'(0);
    end else begin
      s3_wr_r <= s2_valid_r & s2_wr_r;
      if (accept_s) begin
        dst_wren_r <= 1'b0;
        wr_next_r  <= ADDR_W'(0);
      end else if (s3_wr_r) begin
        dst_wren_r <= 1'b1;
        dst_data_r <= next_s & ~clear_r;
        dst_addr_r <= wr_next_r;
        wr_next_r  <= wr_next_r + ADDR_W'(1);
      end else begin
        dst_wren_r <= 1'b0;
      end
    end
  end

`ifdef LIFE_POPCOUNT_EN
  logic [ADDR_W-1:0] pop_acc_r, population_r;
  logic              pop_inc_s;

  assign pop_inc_s = s3_wr_r & next_s & ~clear_r;

  // Count live cells written this run; publish the total on the done cycle.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pop_acc_r    <= ADDR_W'(0);
      population_r <= ADDR_W'(0);
    end else if (accept_s) begin
      pop_acc_r    <= ADDR_W'(0);
    end else begin
      pop_acc_r <= pop_acc_r + ADDR_W'(pop_inc_s);
      if (done_s) begin
        population_r <= pop_acc_r + ADDR_W'(pop_inc_s);
      end else begin
        population_r <= population_r;
      end
    end
  end

  assign bus.population = population_r;
`endif

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.gen_count = gen_count_r;
  assign bus.src_rden  = src_rden_r;
  assign bus.src_addr  = src_addr_r;
  assign bus.dst_wren  = dst_wren_r;
  assign bus.dst_data  = dst_data_r;
  assign bus.dst_addr  = dst_addr_r;

endmodule

// File: tb/tb_life_step_engine.sv
// Self-checking bench for life_step_engine on an 8x6 grid with single-cycle
// RAM models. Expected generations come from a direct neighbour-count model.
module tb_life_step_engine;
  import life_pkg::*;

  localparam int W     = 8;
  localparam int H     = 6;
  localparam int CELLS = W * H;
  localparam int NPOS  = (H + 1) * (W + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  life_step_engine_if #(.ADDR_W(24)) bus ();

  life_step_engine #(.WIDTH(W), .HEIGHT(H), .ADDR_W(24)) dut (
    .clk_in (clk),
    .reset  (reset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_gen = 0;

  int          cyc = 0;
  logic [47:0] src_mem = 48'd0;
  logic [47:0] dst_mem = 48'd0;
  int          wr_total = 0;
  int          rd_total = 0;
  int          done_total = 0;
  int          order_err = 0;
  logic [23:0] exp_addr = 24'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM models and bus monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.src_rden) begin
      rd_total <= rd_total + 1;
      if (bus.src_addr < 24'(CELLS)) bus.src_q <= src_mem[bus.src_addr[5:0]];
      else bus.src_q <= 1'b0;
    end
    if (bus.dst_wren) begin
      wr_total <= wr_total + 1;
      if (bus.dst_addr < 24'(CELLS)) dst_mem[bus.dst_addr[5:0]] <= bus.dst_data;
      if (bus.dst_addr != exp_addr) order_err <= order_err + 1;
    end
    if (bus.done) done_total <= done_total + 1;
    if (bus.done || reset) exp_addr <= 24'd0;
    else if (bus.dst_wren) exp_addr <= exp_addr + 24'd1;
  end

  // Reference: next generation with dead cells outside the grid.
  function automatic logic [47:0] life_ref(input logic [47:0] g);
    logic [47:0] nx;
    int n;
    nx = 48'd0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < H &&
                (c + dc) >= 0 && (c + dc) < W) begin
              if (g[(r + dr) * W + (c + dc)]) n++;
            end
          end
        end
        nx[r * W + c] = (n == 3) || (g[r * W + c] && n == 2);
      end
    end
    return nx;
  endfunction

  task automatic do_gen(input string tag, input logic clr, input int pulse_at,
                        input logic [47:0] exp_grid);
    int   b_wr, b_rd, b_done, b_ord, t0, lat;
    logic seen;
    b_wr = wr_total; b_rd = rd_total; b_done = done_total; b_ord = order_err;
    @(negedge clk);
    bus.start = 1'b1;
    bus.clear_mode = clr;
    t0 = cyc;
    seen = 1'b0;
    lat = 0;
    for (int k = 1; k <= NPOS + 40 && !seen; k++) begin
      @(negedge clk);
      bus.start = (k == pulse_at);
      bus.clear_mode = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        lat = cyc - t0;
      end
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(NPOS + 3));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    exp_gen++;
    check({tag, "_gen_count"}, 64'(bus.gen_count), 64'(exp_gen));
    check({tag, "_writes"}, 64'(wr_total - b_wr), 64'(CELLS));
    check({tag, "_dones"}, 64'(done_total - b_done), 64'd1);
    check({tag, "_order"}, 64'(order_err - b_ord), 64'd0);
    check({tag, "_reads"}, 64'(rd_total - b_rd), clr ? 64'd0 : 64'(CELLS));
    check({tag, "_grid"}, 64'(dst_mem), 64'(exp_grid));
`ifdef LIFE_POPCOUNT_EN
    check({tag, "_population"}, 64'(bus.population), 64'($countones(exp_grid)));
`endif
  endtask

  logic [47:0] g, e;
  logic [63:0] rnd;
  int          b_done;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.clear_mode = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_src_rden", 64'(bus.src_rden), 64'd0);
    check("rst_dst_wren", 64'(bus.dst_wren), 64'd0);
    check("rst_dst_data", 64'(bus.dst_data), 64'd0);
    check("rst_src_addr", 64'(bus.src_addr), 64'd0);
    check("rst_dst_addr", 64'(bus.dst_addr), 64'd0);
    check("rst_gen_count", 64'(bus.gen_count), 64'd0);
`ifdef LIFE_POPCOUNT_EN
    check("rst_population", 64'(bus.population), 64'd0);
`endif

    // Reset in the middle of a run
    rnd = {$urandom, $urandom};
    src_mem = rnd[47:0];
    b_done = done_total;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    check("midrst_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_wren", 64'(bus.dst_wren), 64'd0);
    check("midrst_rden", 64'(bus.src_rden), 64'd0);
    check("midrst_gen_count", 64'(bus.gen_count), 64'(exp_gen));
    repeat (NPOS + 10) @(negedge clk);
    check("midrst_no_done", 64'(done_total - b_done), 64'd0);
    check("midrst_gen_after", 64'(bus.gen_count), 64'(exp_gen));

    // Horizontal blinker becomes vertical
    src_mem = 48'd0;
    src_mem[2 * W + 2] = 1'b1;
    src_mem[2 * W + 3] = 1'b1;
    src_mem[2 * W + 4] = 1'b1;
    e = 48'd0;
    e[1 * W + 3] = 1'b1;
    e[2 * W + 3] = 1'b1;
    e[3 * W + 3] = 1'b1;
    do_gen("blinker", 1'b0, -1, life_ref(src_mem));
    check("blinker_hand", 64'(dst_mem), 64'(e));

    // Still-life block in the corner
    src_mem = 48'd0;
    src_mem[0] = 1'b1; src_mem[1] = 1'b1; src_mem[W] = 1'b1; src_mem[W + 1] = 1'b1;
    do_gen("block", 1'b0, -1, src_mem);

    // Glider against the right edge, buffers swapped each generation
    g = 48'd0;
    g[0 * W + 6] = 1'b1;
    g[1 * W + 7] = 1'b1;
    g[2 * W + 5] = 1'b1;
    g[2 * W + 6] = 1'b1;
    g[2 * W + 7] = 1'b1;
    src_mem = g;
    for (int i = 0; i < 4; i++) begin
      g = life_ref(g);
      do_gen($sformatf("glider%0d", i), 1'b0, -1, g);
      src_mem = dst_mem;
    end

    // Random populations
    for (int i = 0; i < 3; i++) begin
      rnd = {$urandom, $urandom};
      src_mem = rnd[47:0];
      do_gen($sformatf("rand%0d", i), 1'b0, -1, life_ref(src_mem));
    end

    // Clear mode over a full grid
    src_mem = {48{1'b1}};
    do_gen("clear", 1'b1, -1, 48'd0);

    // Second start during a run is ignored
    rnd = {$urandom, $urandom};
    src_mem = rnd[47:0];
    do_gen("restart", 1'b0, 10, life_ref(src_mem));
    repeat (NPOS + 10) @(negedge clk);
    check("restart_idle", 64'(bus.busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
